// File: rtl/control_unit.sv
// control_unit
//   Main instruction decoder of the single-cycle MIPS-style core. Turns a
//   32-bit instruction word into datapath control in the same cycle.
//
// Ports
//   clk            system clock; kept for the datapath port convention, no state
//   reset          active-high; masks write/branch/jump enables while high
//   instruction    op=[31:26] rs=[25:21] rt=[20:16] rd=[15:11] shamt=[10:6] funct=[5:0]
//   reg_write      register-file write enable
//   reg_dst        1: destination rt, 0: destination rd
//   write_reg31    force destination register to $31
//   link           write data = PC+4
//   alu_src        1: ALU B = extended imm16, 0: ALU B = rt value
//   alu_op         ALU operation code (OP_*)
//   ext_op         1: sign-extend imm16, 0: zero-extend
//   mem_write      data-memory write enable
//   mem_to_reg     write data from data memory
//   is_jump        unconditional PC redirect
//   zero_branch    branch taken when ALU zero == need_zero
//   need_zero      required ALU zero value
//   status_branch  branch taken when status Z == need_st_Z
//   need_st_Z      required status Z value
//   pc_select      00 PC+4+(sext imm<<2), 01 {PC[31:28],imm26,00}, 10 rs, 11 mem word
module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        write_reg31,
    output logic        link,
    output logic        alu_src,
    output logic [2:0]  alu_op,
    output logic        ext_op,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        is_jump,
    output logic        zero_branch,
    output logic        need_zero,
    output logic        status_branch,
    output logic        need_st_Z,
    output logic [1:0]  pc_select
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_NOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_JM    = 6'h12;
    localparam logic [5:0] OPC_JALM  = 6'h13;
    localparam logic [5:0] OPC_BZ    = 6'h18;
    localparam logic [5:0] OPC_BN    = 6'h19;
    localparam logic [5:0] OPC_BALZ  = 6'h1A;
    localparam logic [5:0] OPC_BALN  = 6'h1B;
    localparam logic [5:0] OPC_JPC   = 6'h1E;
    localparam logic [5:0] OPC_JALPC = 6'h1F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] OPC_BEQAL = 6'h2C;
    localparam logic [5:0] OPC_BNEAL = 6'h2D;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       rt_is_zero;

    assign opcode     = instruction[31:26];
    assign funct      = instruction[5:0];
    assign rt_is_zero = (instruction[20:16] == 5'd0);

    // Register fields and immediates are consumed by the datapath, not here.
    logic unused_fields;
    assign unused_fields = ^{clk, instruction[25:21], instruction[15:6]};

    always_comb begin
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        write_reg31   = 1'b0;
        link          = 1'b0;
        alu_src       = 1'b0;
        alu_op        = OP_ADD;
        ext_op        = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        is_jump       = 1'b0;
        zero_branch   = 1'b0;
        need_zero     = 1'b0;
        status_branch = 1'b0;
        need_st_Z     = 1'b0;
        pc_select     = 2'b00;

        case (opcode)
            OPC_RTYPE: begin
                reg_write = 1'b1;
                case (funct)
                    FN_SLL:  alu_op = OP_SLL;
                    FN_SRL:  alu_op = OP_SRL;
                    FN_ADD:  alu_op = OP_ADD;
                    FN_SUB:  alu_op = OP_SUB;
                    FN_AND:  alu_op = OP_AND;
                    FN_OR:   alu_op = OP_OR;
                    FN_NOR:  alu_op = OP_NOR;
                    FN_SLT:  alu_op = OP_SLT;
                    FN_JR: begin
                        reg_write = 1'b0;
                        is_jump   = 1'b1;
                        pc_select = 2'b10;
                    end
                    FN_JALR: begin
                        link      = 1'b1;
                        is_jump   = 1'b1;
                        pc_select = 2'b10;
                    end
                    default: reg_write = 1'b0;  // unknown funct behaves as NOP
                endcase
            end
            OPC_ADDI, OPC_SLTI, OPC_ANDI, OPC_ORI: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                alu_src   = 1'b1;
                case (opcode)
                    OPC_ADDI: begin alu_op = OP_ADD; ext_op = 1'b1; end
                    OPC_SLTI: begin alu_op = OP_SLT; ext_op = 1'b1; end
                    OPC_ANDI: alu_op = OP_AND;
                    default:  alu_op = OP_OR;
                endcase
            end
            OPC_LW: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                alu_src    = 1'b1;
                ext_op     = 1'b1;
                mem_to_reg = 1'b1;
            end
            OPC_SW: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                ext_op    = 1'b1;
            end
            OPC_BEQ, OPC_BNE, OPC_BEQAL, OPC_BNEAL: begin
                zero_branch = 1'b1;
                need_zero   = (opcode == OPC_BEQ) || (opcode == OPC_BEQAL);
                alu_op      = OP_SUB;
                ext_op      = 1'b1;
                if (opcode == OPC_BEQAL || opcode == OPC_BNEAL) begin
                    reg_write   = 1'b1;
                    write_reg31 = 1'b1;
                    link        = 1'b1;
                end
            end
            OPC_J, OPC_JAL: begin
                is_jump   = 1'b1;
                pc_select = 2'b01;
                if (opcode == OPC_JAL) begin
                    reg_write   = 1'b1;
                    write_reg31 = 1'b1;
                    link        = 1'b1;
                end
            end
            OPC_BZ, OPC_BN, OPC_BALZ, OPC_BALN: begin
                status_branch = 1'b1;
                need_st_Z     = (opcode == OPC_BZ) || (opcode == OPC_BALZ);
                pc_select     = 2'b01;
                if (opcode == OPC_BALZ || opcode == OPC_BALN) begin
                    reg_write   = 1'b1;
                    write_reg31 = 1'b1;
                    link        = 1'b1;
                end
            end
            OPC_JM, OPC_JALM: begin
                // ALU forms the rs+imm address of the target word
                is_jump   = 1'b1;
                pc_select = 2'b11;
                alu_src   = 1'b1;
                ext_op    = 1'b1;
                if (opcode == OPC_JALM) begin
                    reg_write   = 1'b1;
                    reg_dst     = 1'b1;
                    link        = 1'b1;
                    write_reg31 = rt_is_zero;
                end
            end
            OPC_JPC, OPC_JALPC: begin
                is_jump = 1'b1;
                if (opcode == OPC_JALPC) begin
                    reg_write   = 1'b1;
                    reg_dst     = 1'b1;
                    link        = 1'b1;
                    write_reg31 = rt_is_zero;
                end
            end
            default: ;
        endcase

        // Reset only suppresses side effects; the rest of the decode stays visible.
        if (reset) begin
            reg_write     = 1'b0;
            mem_write     = 1'b0;
            is_jump       = 1'b0;
            zero_branch   = 1'b0;
            status_branch = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
//   Directed-vector bench for control_unit. Each vector carries a hand-derived
//   expected control word; the 18-bit word is laid out as
//   {reg_write, reg_dst, write_reg31, link, alu_src, alu_op[2:0], ext_op,
//    mem_write, mem_to_reg, is_jump, zero_branch, need_zero, status_branch,
//    need_st_Z, pc_select[1:0]}.
module tb_control_unit;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_NOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;

    localparam logic [12:0] NONE = 13'h0000;
    localparam logic [12:0] RW   = 13'h1000;
    localparam logic [12:0] RD   = 13'h0800;
    localparam logic [12:0] W31  = 13'h0400;
    localparam logic [12:0] LNK  = 13'h0200;
    localparam logic [12:0] ASRC = 13'h0100;
    localparam logic [12:0] EO   = 13'h0080;
    localparam logic [12:0] MW   = 13'h0040;
    localparam logic [12:0] M2R  = 13'h0020;
    localparam logic [12:0] J    = 13'h0010;
    localparam logic [12:0] ZB   = 13'h0008;
    localparam logic [12:0] NZ   = 13'h0004;
    localparam logic [12:0] SB   = 13'h0002;
    localparam logic [12:0] NSZ  = 13'h0001;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        reg_write, reg_dst, write_reg31, link, alu_src;
    logic [2:0]  alu_op;
    logic        ext_op, mem_write, mem_to_reg, is_jump;
    logic        zero_branch, need_zero, status_branch, need_st_Z;
    logic [1:0]  pc_select;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    control_unit dut (
        .clk           (clk),
        .reset         (reset),
        .instruction   (instruction),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .write_reg31   (write_reg31),
        .link          (link),
        .alu_src       (alu_src),
        .alu_op        (alu_op),
        .ext_op        (ext_op),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .is_jump       (is_jump),
        .zero_branch   (zero_branch),
        .need_zero     (need_zero),
        .status_branch (status_branch),
        .need_st_Z     (need_st_Z),
        .pc_select     (pc_select)
    );

    always #5 clk = ~clk;

    logic [17:0] obs;
    assign obs = {reg_write, reg_dst, write_reg31, link, alu_src, alu_op,
                  ext_op, mem_write, mem_to_reg, is_jump, zero_branch,
                  need_zero, status_branch, need_st_Z, pc_select};

    function automatic logic [17:0] mk(input logic [12:0] f, input logic [2:0] op,
                                       input logic [1:0] pcs);
        return {f[12:8], op, f[7:0], pcs};
    endfunction

    task automatic test_reset();
        logic [31:0] ins [6];
        logic [17:0] ex  [6];
        ins[0] = 32'h012A4020; ex[0] = mk(NONE, OP_ADD, 2'b00);          // add
        ins[1] = 32'h0C000004; ex[1] = mk(W31 | LNK, OP_ADD, 2'b01);     // jal
        ins[2] = 32'hAD280004; ex[2] = mk(ASRC | EO, OP_ADD, 2'b00);     // sw
        ins[3] = 32'h11280003; ex[3] = mk(NZ | EO, OP_SUB, 2'b00);       // beq
        ins[4] = 32'h60000010; ex[4] = mk(NSZ, OP_ADD, 2'b01);           // bz
        ins[5] = 32'h8D280004; ex[5] = mk(RD | ASRC | EO | M2R, OP_ADD, 2'b00); // lw
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            instruction = ins[i];
            #1;
            vectors++;
            if (obs !== ex[i]) begin
                $display("FAIL reset[%0d] instr=%h got=%b expected=%b", i, ins[i], obs, ex[i]);
                miscompares++;
            end
        end
        // Release mid-instruction: enables return with no clock edge needed.
        @(negedge clk);
        instruction = 32'h012A4020;
        #1;
        reset = 1'b0;
        #1;
        vectors++;
        if (obs !== mk(RW, OP_ADD, 2'b00)) begin
            $display("FAIL reset_release got=%b expected=%b", obs, mk(RW, OP_ADD, 2'b00));
            miscompares++;
        end
    endtask

    task automatic test_rtype();
        logic [31:0] ins [9];
        logic [17:0] ex  [9];
        ins[0] = 32'h00108400; ex[0] = mk(RW, OP_SLL, 2'b00);
        ins[1] = 32'h00104042; ex[1] = mk(RW, OP_SRL, 2'b00);
        ins[2] = 32'h012A4020; ex[2] = mk(RW, OP_ADD, 2'b00);
        ins[3] = 32'h012A4022; ex[3] = mk(RW, OP_SUB, 2'b00);
        ins[4] = 32'h012A4024; ex[4] = mk(RW, OP_AND, 2'b00);
        ins[5] = 32'h012A4025; ex[5] = mk(RW, OP_OR,  2'b00);
        ins[6] = 32'h012A4027; ex[6] = mk(RW, OP_NOR, 2'b00);
        ins[7] = 32'h012A402A; ex[7] = mk(RW, OP_SLT, 2'b00);
        ins[8] = 32'h012A403F; ex[8] = mk(NONE, OP_ADD, 2'b00);          // unknown funct
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            instruction = ins[i];
            #1;
            vectors++;
            if (obs !== ex[i]) begin
                $display("FAIL rtype[%0d] instr=%h got=%b expected=%b", i, ins[i], obs, ex[i]);
                miscompares++;
            end
        end
    endtask

    task automatic test_itype_mem();
        logic [31:0] ins [6];
        logic [17:0] ex  [6];
        ins[0] = 32'h2010FEFE; ex[0] = mk(RW | RD | ASRC | EO, OP_ADD, 2'b00); // addi
        ins[1] = 32'h320900CF; ex[1] = mk(RW | RD | ASRC, OP_AND, 2'b00);      // andi
        ins[2] = 32'h360900C0; ex[2] = mk(RW | RD | ASRC, OP_OR, 2'b00);       // ori
        ins[3] = 32'h292A0005; ex[3] = mk(RW | RD | ASRC | EO, OP_SLT, 2'b00); // slti
        ins[4] = 32'h8D280004; ex[4] = mk(RW | RD | ASRC | EO | M2R, OP_ADD, 2'b00); // lw
        ins[5] = 32'hAD280004; ex[5] = mk(MW | ASRC | EO, OP_ADD, 2'b00);      // sw
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            instruction = ins[i];
            #1;
            vectors++;
            if (obs !== ex[i]) begin
                $display("FAIL itype_mem[%0d] instr=%h got=%b expected=%b", i, ins[i], obs, ex[i]);
                miscompares++;
            end
        end
    endtask

    task automatic test_jumps();
        logic [31:0] ins [10];
        logic [17:0] ex  [10];
        ins[0] = 32'h08000004; ex[0] = mk(J, OP_ADD, 2'b01);                    // j
        ins[1] = 32'h0C000004; ex[1] = mk(RW | W31 | LNK | J, OP_ADD, 2'b01);   // jal
        ins[2] = 32'h03E00008; ex[2] = mk(J, OP_ADD, 2'b10);                    // jr $ra
        ins[3] = 32'h03E0F809; ex[3] = mk(RW | LNK | J, OP_ADD, 2'b10);         // jalr
        ins[4] = 32'h49280010; ex[4] = mk(J | ASRC | EO, OP_ADD, 2'b11);        // jm
        ins[5] = 32'h4D280010; ex[5] = mk(RW | RD | LNK | J | ASRC | EO, OP_ADD, 2'b11);       // jalm rt=8
        ins[6] = 32'h4D200010; ex[6] = mk(RW | RD | W31 | LNK | J | ASRC | EO, OP_ADD, 2'b11); // jalm rt=0
        ins[7] = 32'h78000010; ex[7] = mk(J, OP_ADD, 2'b00);                    // jpc
        ins[8] = 32'h7D280010; ex[8] = mk(RW | RD | LNK | J, OP_ADD, 2'b00);    // jalpc rt=8
        ins[9] = 32'h7C000010; ex[9] = mk(RW | RD | W31 | LNK | J, OP_ADD, 2'b00); // jalpc rt=0
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            instruction = ins[i];
            #1;
            vectors++;
            if (obs !== ex[i]) begin
                $display("FAIL jumps[%0d] instr=%h got=%b expected=%b", i, ins[i], obs, ex[i]);
                miscompares++;
            end
        end
    endtask

    task automatic test_branches();
        logic [31:0] ins [8];
        logic [17:0] ex  [8];
        ins[0] = 32'h11280003; ex[0] = mk(ZB | NZ | EO, OP_SUB, 2'b00);         // beq
        ins[1] = 32'h154BFFFC; ex[1] = mk(ZB | EO, OP_SUB, 2'b00);              // bne
        ins[2] = 32'hB1280003; ex[2] = mk(RW | W31 | LNK | ZB | NZ | EO, OP_SUB, 2'b00); // beqal
        ins[3] = 32'hB5280003; ex[3] = mk(RW | W31 | LNK | ZB | EO, OP_SUB, 2'b00);      // bneal
        ins[4] = 32'h60000010; ex[4] = mk(SB | NSZ, OP_ADD, 2'b01);             // bz
        ins[5] = 32'h64000010; ex[5] = mk(SB, OP_ADD, 2'b01);                   // bn
        ins[6] = 32'h68000010; ex[6] = mk(RW | W31 | LNK | SB | NSZ, OP_ADD, 2'b01); // balz
        ins[7] = 32'h6C000010; ex[7] = mk(RW | W31 | LNK | SB, OP_ADD, 2'b01);  // baln
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            instruction = ins[i];
            #1;
            vectors++;
            if (obs !== ex[i]) begin
                $display("FAIL branches[%0d] instr=%h got=%b expected=%b", i, ins[i], obs, ex[i]);
                miscompares++;
            end
        end
    endtask

    task automatic test_unknown_opcode();
        logic [31:0] ins [3];
        ins[0] = 32'hFC000000;   // op 0x3F
        ins[1] = 32'h04000000;   // op 0x01
        ins[2] = 32'h5FFFFFFF;   // op 0x17
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            instruction = ins[i];
            #1;
            vectors++;
            if (obs !== mk(NONE, OP_ADD, 2'b00)) begin
                $display("FAIL unknown[%0d] instr=%h got=%b expected=%b", i, ins[i], obs,
                         mk(NONE, OP_ADD, 2'b00));
                miscompares++;
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        instruction = 32'h0;
        test_reset();
        test_rtype();
        test_itype_mem();
        test_jumps();
        test_branches();
        test_unknown_opcode();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
